argmax_stream: RTL and testbench

//  Streaming complex-peak finder for the CAF back end, and the successor to the earlier argmax block.
//  Per frame of BUFFER_LENGTH I/Q samples it computes full-precision |x|^2 and reports the peak value and its index.
//  It adds a 2-stage pipeline, output backpressure and reset. An optional feature adds neighbour magnitudes.

---
 rtl/caf_argmax_pkg.sv | 42 ++++
 rtl/argmax_stream_if.sv | 39 +++
 rtl/argmax_stream_cmag_sq.sv | 36 +++
 rtl/argmax_stream.sv | 196 +++++++++++++++++++
 tb/tb_argmax_stream.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/caf_argmax_pkg.sv
// Shared types and helpers for the CAF argmax path: magnitude sizing, the
// S1->S2 pipe record and the shift-and-saturate used on every reported magnitude.
package caf_argmax_pkg;

    function automatic int mag_bits(int i_bits, int q_bits);
        return 2 * ((i_bits > q_bits) ? i_bits : q_bits) + 1;
    endfunction

    function automatic int clog2(int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DEF_BUFFER_LENGTH = 10;
    localparam int DEF_INDEX_BITS    = 4;
    localparam int DEF_I_BITS        = 12;
    localparam int DEF_Q_BITS        = 12;
    localparam int DEF_OUT_MAX_BITS  = 16;
    localparam int DEF_OUT_SHIFT     = 8;

    localparam int PIPE_MAG_BITS = mag_bits(DEF_I_BITS, DEF_Q_BITS);
    localparam int PIPE_POS_BITS = DEF_INDEX_BITS;

    typedef struct packed {
        logic [PIPE_MAG_BITS-1:0] mag;
        logic [PIPE_POS_BITS-1:0] pos;
        logic                     last;
        logic                     valid;
    } pipe_rec_t;

    function automatic logic [63:0] sat_shift(logic [63:0] value, int unsigned shift,
                                              int unsigned out_bits);
        logic [63:0] shifted;
        logic [63:0] limit;
        shifted = value >> shift;
        limit   = (64'd1 << out_bits) - 64'd1;
        return (shifted > limit) ? limit : shifted;
    endfunction

endpackage

// File: rtl/argmax_stream_if.sv
// Sample-in / result-out handshake bundle for argmax_stream.
// ARGMAX_NEIGHBOURS_EN adds the mag_prev / mag_next result fields.
interface argmax_stream_if #(
    parameter int I_BITS       = 12,
    parameter int Q_BITS       = 12,
    parameter int INDEX_BITS   = 4,
    parameter int OUT_MAX_BITS = 16
);
    logic                     m_axis_tvalid;
    logic signed [I_BITS-1:0] xi;
    logic signed [Q_BITS-1:0] xq;
    logic                     s_axis_tready;
    logic                     m_axis_tready;
    logic                     s_axis_tvalid;
    logic [OUT_MAX_BITS-1:0]  out_max;
    logic [INDEX_BITS-1:0]    index;
`ifdef ARGMAX_NEIGHBOURS_EN
    logic [OUT_MAX_BITS-1:0]  mag_prev;
    logic [OUT_MAX_BITS-1:0]  mag_next;

    modport master (
        output m_axis_tvalid, xi, xq, m_axis_tready,
        input  s_axis_tready, s_axis_tvalid, out_max, index, mag_prev, mag_next
    );
    modport slave (
        input  m_axis_tvalid, xi, xq, m_axis_tready,
        output s_axis_tready, s_axis_tvalid, out_max, index, mag_prev, mag_next
    );
`else
    modport master (
        output m_axis_tvalid, xi, xq, m_axis_tready,
        input  s_axis_tready, s_axis_tvalid, out_max, index
    );
    modport slave (
        input  m_axis_tvalid, xi, xq, m_axis_tready,
        output s_axis_tready, s_axis_tvalid, out_max, index
    );
`endif
endinterface

// File: rtl/argmax_stream_cmag_sq.sv
// cmag_sq: registered full-precision |x|^2 with clock enable; shared by CAF blocks.
module cmag_sq
    import caf_argmax_pkg::*;
#(
    parameter int I_BITS   = 12,
    parameter int Q_BITS   = 12,
    parameter int MAG_BITS = mag_bits(I_BITS, Q_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [I_BITS-1:0] xi,
    input  logic signed [Q_BITS-1:0] xq,
    output logic [MAG_BITS-1:0]      mag
);
    logic signed [2*I_BITS-1:0] ii;
    logic signed [2*Q_BITS-1:0] qq;
    logic [MAG_BITS-1:0]        mag_d;
    logic [MAG_BITS-1:0]        mag_q;

    assign ii = xi * xi;
    assign qq = xq * xq;

    // Squares are never negative, so the unsigned view is exact.
    always_comb begin
        mag_d = mag_q;
        if (en) mag_d = MAG_BITS'($unsigned(ii)) + MAG_BITS'($unsigned(qq));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mag_q <= '0;
        else     mag_q <= mag_d;
    end

    assign mag = mag_q;
endmodule

// File: rtl/argmax_stream.sv
// Streaming per-frame |x|^2 peak finder with output backpressure.
// Define ARGMAX_NEIGHBOURS_EN to also report the magnitudes either side of the peak.
module argmax_stream
    import caf_argmax_pkg::*;
#(
    parameter int BUFFER_LENGTH = DEF_BUFFER_LENGTH,
    parameter int INDEX_BITS    = DEF_INDEX_BITS,
    parameter int I_BITS        = DEF_I_BITS,
    parameter int Q_BITS        = DEF_Q_BITS,
    parameter int OUT_MAX_BITS  = DEF_OUT_MAX_BITS,
    parameter int OUT_SHIFT     = DEF_OUT_SHIFT
) (
    input  logic            clk,
    input  logic            rst,
    argmax_stream_if.slave  bus
);
    localparam int MAG_BITS = mag_bits(I_BITS, Q_BITS);
    localparam int CNT_BITS = clog2(BUFFER_LENGTH);

    logic adv;
    logic accept;
    logic upd;
    logic load;

    logic [CNT_BITS-1:0]      cnt_d, cnt_q;
    logic [PIPE_POS_BITS-1:0] s1_pos_d, s1_pos_q;
    logic                     s1_last_d, s1_last_q;
    logic                     s1_valid_d, s1_valid_q;
    logic [MAG_BITS-1:0]      s1_mag;
    pipe_rec_t                s1_rec, p2_d, p2_q;

    logic [PIPE_MAG_BITS-1:0] max_d, max_q;
    logic [PIPE_POS_BITS-1:0] max_pos_d, max_pos_q;

    logic                     out_valid_d, out_valid_q;
    logic [OUT_MAX_BITS-1:0]  out_max_d, out_max_q;
    logic [INDEX_BITS-1:0]    index_d, index_q;

    assign adv              = !(out_valid_q && !bus.m_axis_tready);
    assign accept           = bus.m_axis_tvalid && adv;
    assign bus.s_axis_tready = adv;

    always_comb begin
        cnt_d      = cnt_q;
        s1_pos_d   = s1_pos_q;
        s1_last_d  = s1_last_q;
        s1_valid_d = s1_valid_q;
        if (accept)
            cnt_d = (cnt_q == CNT_BITS'(BUFFER_LENGTH - 1)) ? '0 : cnt_q + 1'b1;
        if (adv) begin
            s1_valid_d = accept;
            s1_pos_d   = PIPE_POS_BITS'(cnt_q);
            s1_last_d  = (cnt_q == CNT_BITS'(BUFFER_LENGTH - 1));
        end
    end

    cmag_sq #(
        .I_BITS   (I_BITS),
        .Q_BITS   (Q_BITS),
        .MAG_BITS (MAG_BITS)
    ) u_cmag_sq (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .xi  (bus.xi),
        .xq  (bus.xq),
        .mag (s1_mag)
    );

    always_comb begin
        s1_rec.mag   = PIPE_MAG_BITS'(s1_mag);
        s1_rec.pos   = s1_pos_q;
        s1_rec.last  = s1_last_q;
        s1_rec.valid = s1_valid_q;
        p2_d         = adv ? s1_rec : p2_q;
    end

    // Strict compare keeps the earliest index on ties; position 0 starts a new frame.
    always_comb begin
        max_d     = max_q;
        max_pos_d = max_pos_q;
        upd  = adv && p2_q.valid && ((p2_q.pos == '0) || (p2_q.mag > max_q));
        load = adv && p2_q.valid && p2_q.last;
        if (upd) begin
            max_d     = p2_q.mag;
            max_pos_d = p2_q.pos;
        end
    end

    // A new result takes priority over clearing the one being accepted.
    always_comb begin
        out_valid_d = out_valid_q;
        out_max_d   = out_max_q;
        index_d     = index_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_max_d   = OUT_MAX_BITS'(sat_shift(64'(max_d), OUT_SHIFT, OUT_MAX_BITS));
            index_d     = INDEX_BITS'(max_pos_d);
        end else if (out_valid_q && bus.m_axis_tready) begin
            out_valid_d = 1'b0;
            out_max_d   = '0;
            index_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            s1_pos_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            p2_q        <= '0;
            max_q       <= '0;
            max_pos_q   <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            index_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            s1_pos_q    <= s1_pos_d;
            s1_last_q   <= s1_last_d;
            s1_valid_q  <= s1_valid_d;
            p2_q        <= p2_d;
            max_q       <= max_d;
            max_pos_q   <= max_pos_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            index_q     <= index_d;
        end
    end

    assign bus.s_axis_tvalid = out_valid_q;
    assign bus.out_max       = out_max_q;
    assign bus.index         = index_q;

`ifdef ARGMAX_NEIGHBOURS_EN
    logic [PIPE_MAG_BITS-1:0] prev_mag_d, prev_mag_q;
    logic [PIPE_MAG_BITS-1:0] pk_prev_d, pk_prev_q;
    logic [PIPE_MAG_BITS-1:0] pk_next_d, pk_next_q;
    logic                     need_next_d, need_next_q;
    logic [OUT_MAX_BITS-1:0]  mag_prev_d, mag_prev_q;
    logic [OUT_MAX_BITS-1:0]  mag_next_d, mag_next_q;

    // The sample after a new peak supplies mag_next; a peak on the last sample has none.
    always_comb begin
        prev_mag_d  = prev_mag_q;
        pk_prev_d   = pk_prev_q;
        pk_next_d   = pk_next_q;
        need_next_d = need_next_q;
        if (adv && p2_q.valid) begin
            prev_mag_d = p2_q.mag;
            if (upd) begin
                pk_prev_d   = (p2_q.pos == '0) ? '0 : prev_mag_q;
                pk_next_d   = '0;
                need_next_d = !p2_q.last;
            end else if (need_next_q) begin
                pk_next_d   = p2_q.mag;
                need_next_d = 1'b0;
            end
        end
    end

    always_comb begin
        mag_prev_d = mag_prev_q;
        mag_next_d = mag_next_q;
        if (load) begin
            mag_prev_d = OUT_MAX_BITS'(sat_shift(64'(pk_prev_d), OUT_SHIFT, OUT_MAX_BITS));
            mag_next_d = OUT_MAX_BITS'(sat_shift(64'(pk_next_d), OUT_SHIFT, OUT_MAX_BITS));
        end else if (out_valid_q && bus.m_axis_tready) begin
            mag_prev_d = '0;
            mag_next_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_mag_q  <= '0;
            pk_prev_q   <= '0;
            pk_next_q   <= '0;
            need_next_q <= 1'b0;
            mag_prev_q  <= '0;
            mag_next_q  <= '0;
        end else begin
            prev_mag_q  <= prev_mag_d;
            pk_prev_q   <= pk_prev_d;
            pk_next_q   <= pk_next_d;
            need_next_q <= need_next_d;
            mag_prev_q  <= mag_prev_d;
            mag_next_q  <= mag_next_d;
        end
    end

    assign bus.mag_prev = mag_prev_q;
    assign bus.mag_next = mag_next_q;
`endif
endmodule

// File: tb/tb_argmax_stream.sv
// Directed self-checking bench for argmax_stream (OUT_SHIFT=0, 10-sample frames).
module tb_argmax_stream;
    typedef int frame_t [10];

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    argmax_stream_if #(.I_BITS(12), .Q_BITS(12), .INDEX_BITS(4), .OUT_MAX_BITS(16)) bus ();

    argmax_stream #(
        .BUFFER_LENGTH (10),
        .INDEX_BITS    (4),
        .I_BITS        (12),
        .Q_BITS        (12),
        .OUT_MAX_BITS  (16),
        .OUT_SHIFT     (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic send_range(input frame_t fi, input frame_t fq, input int first, input int last_i);
        for (int k = first; k <= last_i; k++) begin
            int budget;
            @(negedge clk);
            bus.m_axis_tvalid = 1'b1;
            bus.xi = 12'(fi[k]);
            bus.xq = 12'(fq[k]);
            budget = 0;
            while (!bus.s_axis_tready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sample %0d never accepted, s_axis_tready=%b required=1", k, bus.s_axis_tready);
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.m_axis_tvalid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (bus.s_axis_tvalid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.s_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: s_axis_tvalid=%b required=1", name, bus.s_axis_tvalid);
        end
    endtask

    task automatic check_result(input string name, input int exp_idx, input int exp_max);
        checks++;
        if (bus.index !== 4'(exp_idx)) begin
            errors++;
            $display("FAIL %s_index: got %0d required %0d", name, bus.index, exp_idx);
        end
        checks++;
        if (bus.out_max !== 16'(exp_max)) begin
            errors++;
            $display("FAIL %s_out_max: got %0d required %0d", name, bus.out_max, exp_max);
        end
    endtask

    task automatic release_result(input string name);
        bus.m_axis_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear: s_axis_tvalid=%b required=0", name, bus.s_axis_tvalid);
        end
        bus.m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b0;
        bus.xi = '0;
        bus.xq = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", bus.s_axis_tvalid); end
        checks++;
        if (bus.out_max !== 16'd0) begin errors++; $display("FAIL reset_out_max: got %0d required 0", bus.out_max); end
        checks++;
        if (bus.index !== 4'd0) begin errors++; $display("FAIL reset_index: got %0d required 0", bus.index); end
        checks++;
        if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b required 1", bus.s_axis_tready); end
    endtask

    task automatic test_peak();
        frame_t fi, fq;
        fi = '{1, 2, 3, 10, 3, 2, 1, 0, 0, 0};
        fq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        bus.m_axis_tready = 1'b0;
        send_range(fi, fq, 0, 9);
        go_idle();
        checks++;
        if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("FAIL peak_latency_t0: tvalid=%b required 0", bus.s_axis_tvalid); end
        @(negedge clk);
        checks++;
        if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("FAIL peak_latency_t1: tvalid=%b required 0", bus.s_axis_tvalid); end
        @(negedge clk);
        checks++;
        if (bus.s_axis_tvalid !== 1'b1) begin errors++; $display("FAIL peak_latency_t2: tvalid=%b required 1", bus.s_axis_tvalid); end
        check_result("peak", 3, 100);
        release_result("peak");
    endtask

    task automatic test_tie();
        frame_t fi, fq;
        fi = '{1, 2, 7, 3, 6, 2, 1, 5, 4, 0};
        fq = '{0, 1, 1, 3, 3, 0, 2, 5, 0, 0};
        send_range(fi, fq, 0, 9);
        go_idle();
        wait_result("tie");
        check_result("tie", 2, 50);
        release_result("tie");
    endtask

    task automatic test_backpressure();
        frame_t fa, fb, fz;
        fa = '{0, 1, 2, 3, 4, 9, 2, 1, 0, 3};
        fb = '{11, 2, 3, 1, 0, 4, 12, 5, 1, 2};
        fz = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        bus.m_axis_tready = 1'b0;
        send_range(fa, fz, 0, 9);
        go_idle();
        wait_result("bp_a");
        check_result("bp_a", 5, 81);
        for (int c = 0; c < 5; c++) begin
            bus.m_axis_tvalid = 1'b1;
            bus.xi = 12'(fb[0]);
            bus.xq = 12'd0;
            checks++;
            if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_stall_tready: cycle %0d got %b required 0", c, bus.s_axis_tready); end
            checks++;
            if (bus.s_axis_tvalid !== 1'b1 || bus.index !== 4'd5 || bus.out_max !== 16'd81) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got valid=%b index=%0d out_max=%0d required 1/5/81", c, bus.s_axis_tvalid, bus.index, bus.out_max);
            end
            @(negedge clk);
        end
        bus.m_axis_tready = 1'b1;
        send_range(fb, fz, 1, 9);
        go_idle();
        wait_result("bp_b");
        check_result("bp_b", 6, 144);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        frame_t fj, fc, fz;
        fj = '{100, 100, 100, 100, 0, 0, 0, 0, 0, 0};
        fc = '{20, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        fz = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        bus.m_axis_tready = 1'b1;
        send_range(fj, fz, 0, 3);
        @(negedge clk);
        bus.m_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b required 0", bus.s_axis_tvalid); end
        send_range(fc, fz, 0, 9);
        go_idle();
        wait_result("rstmid");
        check_result("rstmid", 0, 400);
        @(negedge clk);
        checks++;
        if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_extra: tvalid=%b required 0", bus.s_axis_tvalid); end
    endtask

    task automatic test_extremes();
        frame_t fi;
        fi = '{0, 0, 0, -2048, 0, 2047, 0, 0, 0, 0};
        bus.m_axis_tready = 1'b0;
        send_range(fi, fi, 0, 9);
        go_idle();
        wait_result("extreme");
        check_result("extreme", 3, 65535);
        release_result("extreme");
    endtask

    task automatic test_neighbours();
        frame_t f0, f9, fz;
        f0 = '{30, 5, 1, 2, 3, 0, 1, 2, 3, 4};
        f9 = '{1, 2, 3, 4, 5, 1, 2, 3, 6, 40};
        fz = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        bus.m_axis_tready = 1'b0;
        send_range(f0, fz, 0, 9);
        go_idle();
        wait_result("nb0");
        check_result("nb0", 0, 900);
`ifdef ARGMAX_NEIGHBOURS_EN
        checks++;
        if (bus.mag_prev !== 16'd0) begin errors++; $display("FAIL nb0_prev: got %0d required 0", bus.mag_prev); end
        checks++;
        if (bus.mag_next !== 16'd25) begin errors++; $display("FAIL nb0_next: got %0d required 25", bus.mag_next); end
`endif
        release_result("nb0");
        send_range(f9, fz, 0, 9);
        go_idle();
        wait_result("nb9");
        check_result("nb9", 9, 1600);
`ifdef ARGMAX_NEIGHBOURS_EN
        checks++;
        if (bus.mag_prev !== 16'd36) begin errors++; $display("FAIL nb9_prev: got %0d required 36", bus.mag_prev); end
        checks++;
        if (bus.mag_next !== 16'd0) begin errors++; $display("FAIL nb9_next: got %0d required 0", bus.mag_next); end
`endif
        release_result("nb9");
    endtask

    task automatic test_back_to_back();
        frame_t fd, fe, fz;
        int exp_idx [2];
        fd = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1};
        fe = '{9, 1, 1, 1, 1, 1, 1, 1, 1, 2};
        fz = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_idx = '{8, 0};
        bus.m_axis_tready = 1'b1;
        fork
            begin
                send_range(fd, fz, 0, 9);
                send_range(fe, fz, 0, 9);
                go_idle();
            end
            begin
                for (int r = 0; r < 2; r++) begin
                    int n;
                    n = 0;
                    @(negedge clk);
                    while (bus.s_axis_tvalid !== 1'b1 && n < 60) begin
                        @(negedge clk);
                        n++;
                    end
                    checks++;
                    if (bus.s_axis_tvalid !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_timeout: result %0d tvalid=%b required 1", r, bus.s_axis_tvalid);
                    end
                    check_result("b2b", exp_idx[r], 81);
                end
            end
        join
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_peak();
        test_tie();
        test_backpressure();
        test_reset_mid_frame();
        test_extremes();
        test_neighbours();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
